// File: rtl/fbag_pkg.sv
// Shared types and width helpers for the frame-bank write sequencer.
package fbag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    READ  = 2'd3
  } fbag_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fbag_delay_pipe.sv
// Resettable shift pipe of DEPTH stages; DEPTH=0 is a straight wire.
module fbag_delay_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] q;
        if (gi == 0) begin : g_first
          assign prev = din;
        end else begin : g_rest
          assign prev = g_stage[gi-1].q;
        end
        always_ff @(posedge clk) begin
          if (rst) q <= '0;
          else     q <= prev;
        end
      end
      assign dout = g_stage[DEPTH-1].q;
    end
  endgenerate

endmodule

// File: rtl/frame_bank_addr_gen.sv
// Frame-buffer write sequencer spreading one frame across NUM_BANKS RAM banks.
// Define FBAG_READBACK_EN to add a linear readback scan (READ state, rb_* ports).
module frame_bank_addr_gen
  import fbag_pkg::*;
#(
  parameter int unsigned NUM_BANKS    = 16,
  parameter int unsigned BANK_DEPTH   = 65536,
  parameter int unsigned FRAME_PIXELS = 1036800,
  parameter int unsigned RD_LAT       = 1,
  localparam int ADDR_W = clog2w(BANK_DEPTH),
  localparam int BSEL_W = clog2w(NUM_BANKS),
  localparam int CNT_W  = clog2w(FRAME_PIXELS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef FBAG_READBACK_EN
  input  logic                 rb_start,
  output logic                 rb_valid,
  output logic [BSEL_W-1:0]    rb_bank,
  output logic [ADDR_W-1:0]    rb_addr,
`endif
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  output logic                 pix_ready,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [BSEL_W-1:0]    wr_bank,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic [BSEL_W-1:0]    rd_bank,
  output logic                 frame_done,
  output logic                 sof_err,
  output logic                 busy
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BANK_DEPTH - 1);
  localparam logic [BSEL_W-1:0] BANK_LAST = BSEL_W'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_PIXELS - 1);

  fbag_state_e          state_q, state_d;
  logic [BSEL_W-1:0]    bank_q, bank_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_BANKS-1:0] wr_en_q, wr_en_d;
  logic [BSEL_W-1:0]    wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic                 sof_err_q, sof_err_d;
  logic                 accept, restart, do_write;
  logic [BSEL_W-1:0]    beat_bank;
  logic [ADDR_W-1:0]    beat_addr;
  logic [CNT_W-1:0]     beat_cnt;
`ifdef FBAG_READBACK_EN
  logic [BSEL_W-1:0]    rb_bank_q, rb_bank_d;
  logic [ADDR_W-1:0]    rb_addr_q, rb_addr_d;
  logic [CNT_W-1:0]     rb_cnt_q, rb_cnt_d;
`endif

  // Position that follows (b, a); the bank wraps explicitly rather than by overflow.
  function automatic logic [BSEL_W+ADDR_W-1:0] advance(input logic [BSEL_W-1:0] b,
                                                       input logic [ADDR_W-1:0] a);
    logic [BSEL_W-1:0] nb;
    logic [ADDR_W-1:0] na;
    nb = b;
    na = a + ADDR_W'(1);
    if (a == ADDR_LAST) begin
      na = '0;
      nb = (b == BANK_LAST) ? '0 : b + BSEL_W'(1);
    end
    return {nb, na};
  endfunction

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_en_d   = '0;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    sof_err_d = 1'b0;
    do_write  = 1'b0;
`ifdef FBAG_READBACK_EN
    rb_bank_d = rb_bank_q;
    rb_addr_d = rb_addr_q;
    rb_cnt_d  = rb_cnt_q;
`endif
    pix_ready = ((state_q == IDLE) || (state_q == WRITE)) && !rst;
    accept    = pix_valid && pix_ready;
    // An SOF beat (or the first beat from IDLE) always lands on pixel 0.
    restart   = (state_q == IDLE) || pix_sof;
    beat_bank = restart ? '0 : bank_q;
    beat_addr = restart ? '0 : addr_q;
    beat_cnt  = restart ? '0 : cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept && pix_sof) begin
          do_write = 1'b1;
`ifdef FBAG_READBACK_EN
        end else if (rb_start) begin
          state_d   = READ;
          rb_bank_d = '0;
          rb_addr_d = '0;
          rb_cnt_d  = '0;
`endif
        end
      end
      WRITE: begin
        if (accept) begin
          do_write  = 1'b1;
          sof_err_d = pix_sof;
        end
      end
      DONE: begin
`ifdef FBAG_READBACK_EN
        state_d   = READ;
        rb_bank_d = '0;
        rb_addr_d = '0;
        rb_cnt_d  = '0;
`else
        state_d = IDLE;
`endif
      end
      READ: begin
`ifdef FBAG_READBACK_EN
        {rb_bank_d, rb_addr_d} = advance(rb_bank_q, rb_addr_q);
        rb_cnt_d = rb_cnt_q + CNT_W'(1);
        if (rb_cnt_q == CNT_LAST) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (do_write) begin
      wr_en_d   = NUM_BANKS'(1) << beat_bank;
      wr_bank_d = beat_bank;
      wr_addr_d = beat_addr;
      {bank_d, addr_d} = advance(beat_bank, beat_addr);
      cnt_d   = beat_cnt + CNT_W'(1);
      state_d = (beat_cnt == CNT_LAST) ? DONE : WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bank_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= '0;
      wr_bank_q <= '0;
      wr_addr_q <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      sof_err_q <= sof_err_d;
    end
  end

`ifdef FBAG_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_bank_q <= '0;
      rb_addr_q <= '0;
      rb_cnt_q  <= '0;
    end else begin
      rb_bank_q <= rb_bank_d;
      rb_addr_q <= rb_addr_d;
      rb_cnt_q  <= rb_cnt_d;
    end
  end

  assign rb_valid = (state_q == READ);
  assign rb_bank  = rb_bank_q;
  assign rb_addr  = rb_addr_q;
`endif

  fbag_delay_pipe #(
    .WIDTH (BSEL_W + ADDR_W),
    .DEPTH (RD_LAT)
  ) u_rd_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  ({wr_bank_q, wr_addr_q}),
    .dout ({rd_bank, rd_addr})
  );

  assign wr_en      = wr_en_q;
  assign wr_bank    = wr_bank_q;
  assign wr_addr    = wr_addr_q;
  assign sof_err    = sof_err_q;
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule
